// File: rtl/i2s_pkg.sv
// i2s_pkg -- shared constants and helpers for the I2S microphone receiver.
//   SLOT_BITS  : bits per channel slot
//   FRAME_BITS : bits per stereo frame (left + right slot)
//   BITCNT_W   : width of the frame bit counter
//   bit_cnt_inc: wrapping increment of the frame bit position
package i2s_pkg;

    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned BITCNT_W   = $clog2(FRAME_BITS);

    // Frame bit positions with special meaning
    localparam logic [BITCNT_W-1:0] BIT_FIRST  = BITCNT_W'(0);
    localparam logic [BITCNT_W-1:0] BIT_SLOT_R = BITCNT_W'(SLOT_BITS);
    localparam logic [BITCNT_W-1:0] BIT_LAST   = BITCNT_W'(FRAME_BITS - 1);

    // Next frame bit position; wraps from the last position back to 0
    function automatic logic [BITCNT_W-1:0] bit_cnt_inc(input logic [BITCNT_W-1:0] cnt);
        logic [BITCNT_W-1:0] nxt;
        if (cnt == BIT_LAST) begin
            nxt = BIT_FIRST;
        end else begin
            nxt = cnt + BITCNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/i2s_mic_rx_if.sv
// i2s_mic_rx_if -- frame hand-off between the I2S receiver core and its consumer.
//   sample_l / sample_r : last accepted left/right slot words
//   sample_vld          : an un-acked frame is held in sample_l/sample_r
//   sample_ack          : consumer takes the frame
//   overrun             : sticky, a frame was dropped because the previous one was un-acked
//   ovr_clr             : consumer clears overrun
// modport master = receiver core, modport slave = consumer.
interface i2s_mic_rx_if;
    import i2s_pkg::*;

    logic [SLOT_BITS-1:0] sample_l;
    logic [SLOT_BITS-1:0] sample_r;
    logic                 sample_vld;
    logic                 sample_ack;
    logic                 overrun;
    logic                 ovr_clr;

    modport master (
        output sample_l, sample_r, sample_vld, overrun,
        input  sample_ack, ovr_clr
    );

    modport slave (
        input  sample_l, sample_r, sample_vld, overrun,
        output sample_ack, ovr_clr
    );

endinterface

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen -- I2S bit-clock generator.
//   clk          : HCLK
//   rst          : synchronous active-high reset
//   en           : 1 = run, 0 = force SCK low and clear the divider next cycle
//   sck          : registered bit clock, idle low, SCK = clk / (2*CLK_DIV)
//   fall_tick    : cycle whose closing edge drives SCK 1->0
//   rise_tick    : cycle whose closing edge drives SCK 0->1
//   capture_tick : last HCLK of the SCK high phase (the data sampling point)
module i2s_sck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic fall_tick,
    output logic rise_tick,
    output logic capture_tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_r;
    logic       sck_r;
    logic       at_last_s;

    assign at_last_s = (div_cnt_r == DIV_LAST);

    // Ticks are gated by en so nothing fires in the cycle an abort is requested.
    // The last high-phase HCLK is exactly the one whose terminal count drops SCK,
    // so the capture tick and the fall tick coincide.
    assign fall_tick    = en & at_last_s & sck_r;
    assign rise_tick    = en & at_last_s & ~sck_r;
    assign capture_tick = en & at_last_s & sck_r;
    assign sck          = sck_r;

    // Half-period divider and SCK toggle register
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= 8'd0;
            sck_r     <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= 8'd0;
            sck_r     <= 1'b0;
        end else if (at_last_s) begin
            div_cnt_r <= 8'd0;
            sck_r     <= ~sck_r;
        end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx -- I2S master receiver for a stereo microphone.
//   HCLK     : single clock
//   HRESET   : synchronous active-high reset
//   en       : 1 = generate SCK/WS and capture, 0 = idle/abort current frame
//   SD       : serial data from the microphone, asynchronous
//   SCK, WS  : I2S bit clock (idle low) and word select (0 = left slot)
//   bus      : frame hand-off (sample_l/r, sample_vld/ack, overrun/ovr_clr)
// Standard I2S framing with the 1-bit delay: the left word occupies positions
// 1..SLOT_BITS, the right word SLOT_BITS+1..FRAME_BITS-1 plus position 0 of the
// following frame, whose capture completes the frame.
module i2s_mic_rx
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         en,
    input  logic         SD,
    output logic         SCK,
    output logic         WS,
    i2s_mic_rx_if.master bus
);

    logic                 sck_s;
    logic                 fall_tick_s;
    logic                 rise_tick_s;
    logic                 capture_tick_s;

    logic                 sd_meta_r;
    logic                 sd_sync_r;

    logic [BITCNT_W-1:0]  bit_cnt_r;
    logic [BITCNT_W-1:0]  bit_cnt_nxt_s;
    logic                 ws_r;
    logic [SLOT_BITS-1:0] shift_r;
    logic [SLOT_BITS-1:0] shift_nxt_s;
    logic [SLOT_BITS-1:0] left_hold_r;
    logic                 left_ok_r;
    logic                 armed_r;
    logic                 capture_s;
    logic                 frame_done_s;
    logic                 ovr_set_s;

    logic [SLOT_BITS-1:0] sample_l_r;
    logic [SLOT_BITS-1:0] sample_r_r;
    logic                 sample_vld_r;
    logic                 overrun_r;

    i2s_sck_gen #(
        .CLK_DIV      (CLK_DIV)
    ) u_sck_gen (
        .clk          (HCLK),
        .rst          (HRESET),
        .en           (en),
        .sck          (sck_s),
        .fall_tick    (fall_tick_s),
        .rise_tick    (rise_tick_s),
        .capture_tick (capture_tick_s)
    );

    assign bit_cnt_nxt_s = bit_cnt_inc(bit_cnt_r);
    assign shift_nxt_s   = {shift_r[SLOT_BITS-2:0], sd_sync_r};

    // A capture is only honoured after the matching rising edge was generated.
    assign capture_s     = capture_tick_s & armed_r;

    // Position 0 completes a frame only once a left word exists; this discards
    // position 0 of the first frame after en rises.
    assign frame_done_s  = capture_s & (bit_cnt_r == BIT_FIRST) & left_ok_r;
    assign ovr_set_s     = frame_done_s & sample_vld_r & ~bus.sample_ack;

    // Two-flop synchroniser for the asynchronous SD input
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sd_meta_r <= 1'b0;
            sd_sync_r <= 1'b0;
        end else begin
            sd_meta_r <= SD;
            sd_sync_r <= sd_meta_r;
        end
    end

    // Bit position, word select, shift register and left-word latch
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bit_cnt_r   <= BIT_FIRST;
            ws_r        <= 1'b0;
            shift_r     <= '0;
            left_hold_r <= '0;
            left_ok_r   <= 1'b0;
            armed_r     <= 1'b0;
        end else if (!en) begin
            bit_cnt_r   <= BIT_FIRST;
            ws_r        <= 1'b0;
            shift_r     <= '0;
            left_hold_r <= '0;
            left_ok_r   <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            if (rise_tick_s) begin
                armed_r <= 1'b1;
            end else if (capture_s) begin
                armed_r <= 1'b0;
            end
            if (capture_s) begin
                shift_r <= shift_nxt_s;
                if (bit_cnt_r == BIT_SLOT_R) begin
                    left_hold_r <= shift_nxt_s;
                    left_ok_r   <= 1'b1;
                end
            end
            // WS follows the position being entered, changing on the SCK fall
            if (fall_tick_s) begin
                bit_cnt_r <= bit_cnt_nxt_s;
                ws_r      <= (bit_cnt_nxt_s >= BIT_SLOT_R);
            end
        end
    end

    // Frame hand-off: load or drop completed frames, ack handling, sticky overrun
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sample_l_r   <= '0;
            sample_r_r   <= '0;
            sample_vld_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (frame_done_s) begin
                // An ack in the completion cycle frees the holding registers in time
                if (!sample_vld_r || bus.sample_ack) begin
                    sample_l_r   <= left_hold_r;
                    sample_r_r   <= shift_nxt_s;
                    sample_vld_r <= 1'b1;
                end
            end else if (sample_vld_r && bus.sample_ack) begin
                sample_vld_r <= 1'b0;
            end
            // Set has priority over clear
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign SCK            = sck_s;
    assign WS             = ws_r;
    assign bus.sample_l   = sample_l_r;
    assign bus.sample_r   = sample_r_r;
    assign bus.sample_vld = sample_vld_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx -- self-checking bench for i2s_mic_rx.
// The microphone and the expected outputs are both derived from a single count
// of enabled HCLK cycles: SCK cycle k = n / (2*CLK_DIV), frame bit = k % FRAME_BITS.
// Frame f carries words fl[f]/fr[f]; a frame is delivered at the capture of
// position 0 of the following frame.
module tb_i2s_mic_rx;
    import i2s_pkg::*;

    localparam int D  = 4;
    localparam int FB = FRAME_BITS;
    localparam int SB = SLOT_BITS;

    logic HCLK = 1'b0;
    logic HRESET;
    logic en;
    logic SD;
    logic SCK;
    logic WS;

    i2s_mic_rx_if bus ();

    i2s_mic_rx #(.CLK_DIV(D)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .en     (en),
        .SD     (SD),
        .SCK    (SCK),
        .WS     (WS),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int          vec_cnt;
    int          err_cnt;

    // reference model state
    int          n;
    bit          m_done;
    logic        m_vld;
    logic        m_ovr;
    logic [31:0] m_l;
    logic [31:0] m_r;
    logic [31:0] fl [16];
    logic [31:0] fr [16];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic new_frames();
        for (int i = 0; i < 16; i++) begin
            fl[i] = $urandom;
            fr[i] = $urandom;
        end
    endtask

    // bit the microphone presents during enabled cycle count nn
    function automatic logic mic_bit(input int nn);
        int k;
        int f;
        int p;
        k = nn / (2 * D);
        f = k / FB;
        p = k % FB;
        if (f > 15) return 1'b0;
        if (p == 0) return (f > 0) ? fr[f-1][0] : 1'b0;
        if (p <= SB) return fl[f][SB-p];
        return fr[f][FB-p];
    endfunction

    // does the edge ending enabled cycle count nn capture position 0 of frame >= 1
    function automatic bit completes_at(input int nn);
        int k;
        if (nn <= 0 || (nn % (2 * D)) != 0) return 1'b0;
        k = nn / (2 * D) - 1;
        return (k > 0) && ((k % FB) == 0);
    endfunction

    task automatic model_step();
        int idx;
        bit set_ovr;
        m_done  = 1'b0;
        set_ovr = 1'b0;
        if (HRESET) begin
            n     = 0;
            m_vld = 1'b0;
            m_ovr = 1'b0;
            m_l   = 32'h0;
            m_r   = 32'h0;
        end else begin
            idx = 0;
            if (en) begin
                n++;
                if (completes_at(n)) begin
                    m_done = 1'b1;
                    idx    = (n / (2 * D) - 1) / FB - 1;
                end
            end else begin
                n = 0;
            end
            if (m_done) begin
                if (!m_vld || bus.sample_ack) begin
                    m_l   = fl[idx];
                    m_r   = fr[idx];
                    m_vld = 1'b1;
                end else begin
                    set_ovr = 1'b1;
                end
            end else if (m_vld && bus.sample_ack) begin
                m_vld = 1'b0;
            end
            if (set_ovr) m_ovr = 1'b1;
            else if (bus.ovr_clr) m_ovr = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("sck", 32'(SCK), 32'((n / D) % 2));
        check_eq("ws", 32'(WS), 32'(((n / (2 * D)) % FB) >= SB));
        check_eq("vld", 32'(bus.sample_vld), 32'(m_vld));
        check_eq("overrun", 32'(bus.overrun), 32'(m_ovr));
        check_eq("sample_l", bus.sample_l, m_l);
        check_eq("sample_r", bus.sample_r, m_r);
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_step();
        #1;
        check_all();
        SD = mic_bit(n);
    endtask

    task automatic rand_hs();
        bus.sample_ack = ($urandom_range(0, 99) < 3);
        bus.ovr_clr    = ($urandom_range(0, 199) == 0);
    endtask

    task automatic quiet_hs();
        bus.sample_ack = 1'b0;
        bus.ovr_clr    = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (!m_done && c < limit);
        check_eq("done_within_bound", 32'(m_done), 32'd1);
    endtask

    // stop one cycle before a completion edge
    task automatic wait_pre_done(input int limit);
        int c;
        c = 0;
        while (!(en && completes_at(n + 1)) && c < limit) begin
            tick();
            c++;
        end
        check_eq("pre_done_within_bound", 32'(en && completes_at(n + 1)), 32'd1);
    endtask

    task automatic run_random_until(input int target, input int limit);
        int c;
        c = 0;
        while (n != target && c < limit) begin
            rand_hs();
            tick();
            c++;
        end
        quiet_hs();
        check_eq("target_within_bound", n, target);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        n       = 0;
        m_done  = 1'b0;
        m_vld   = 1'b0;
        m_ovr   = 1'b0;
        m_l     = 32'h0;
        m_r     = 32'h0;
        HRESET  = 1'b1;
        en      = 1'b1;
        SD      = 1'b0;
        quiet_hs();
        new_frames();
        fl[0] = 32'hA5A51234;
        fr[0] = 32'h0F0FF0F0;
        fl[1] = 32'h11111111;

        // reset with en high
        repeat (3) tick();
        check_eq("rst_sck", 32'(SCK), 32'd0);
        check_eq("rst_vld", 32'(bus.sample_vld), 32'd0);
        HRESET = 1'b0;

        // first frame delivered
        wait_done(1000);
        check_eq("f0_l", bus.sample_l, 32'hA5A51234);
        check_eq("f0_r", bus.sample_r, 32'h0F0FF0F0);
        check_eq("f0_vld", 32'(bus.sample_vld), 32'd1);

        // second frame while un-acked -> dropped, overrun
        wait_done(1000);
        check_eq("ovr_keep_l", bus.sample_l, 32'hA5A51234);
        check_eq("ovr_set", 32'(bus.overrun), 32'd1);
        repeat (5) tick();
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        check_eq("ovr_clr", 32'(bus.overrun), 32'd0);

        // clear coincident with a new overrun: set wins
        wait_pre_done(1000);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        check_eq("ovr_set_wins", 32'(bus.overrun), 32'd1);

        // ack drops vld; ack with vld low is ignored
        bus.sample_ack = 1'b1;
        tick();
        check_eq("ack_drop_vld", 32'(bus.sample_vld), 32'd0);
        tick();
        bus.sample_ack = 1'b0;
        check_eq("ack_idle_l", bus.sample_l, 32'hA5A51234);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;

        wait_done(1000);
        check_eq("f3_l", bus.sample_l, fl[3]);

        // ack in the completion cycle: new frame loaded, vld stays, no overrun
        wait_pre_done(1000);
        bus.sample_ack = 1'b1;
        tick();
        bus.sample_ack = 1'b0;
        check_eq("ack_same_vld", 32'(bus.sample_vld), 32'd1);
        check_eq("ack_same_ovr", 32'(bus.overrun), 32'd0);
        check_eq("ack_same_l", bus.sample_l, fl[4]);
        check_eq("ack_same_r", bus.sample_r, fr[4]);

        // random handshake, then abort inside the high phase of bit 17 of frame 10
        run_random_until(2 * D * (FB * 10 + 17) + D + 1, 10000);
        check_eq("pre_abort_sck", 32'(SCK), 32'd1);
        en = 1'b0;
        tick();
        check_eq("abort_sck", 32'(SCK), 32'd0);
        check_eq("abort_ws", 32'(WS), 32'd0);
        repeat (10) begin
            rand_hs();
            tick();
        end
        bus.sample_ack = 1'b1;
        tick();
        bus.sample_ack = 1'b0;
        check_eq("ack_while_idle", 32'(bus.sample_vld), 32'd0);

        // restart: first delivery only after one full new frame
        new_frames();
        en = 1'b1;
        wait_done(1200);
        check_eq("restart_l", bus.sample_l, fl[0]);
        check_eq("restart_r", bus.sample_r, fr[0]);

        // reset inside the right slot (WS high)
        run_random_until(2 * D * (FB * 2 + 40) + D + 1, 3000);
        check_eq("pre_rst_ws", 32'(WS), 32'd1);
        HRESET = 1'b1;
        tick();
        check_eq("midrst_sck", 32'(SCK), 32'd0);
        check_eq("midrst_ws", 32'(WS), 32'd0);
        check_eq("midrst_vld", 32'(bus.sample_vld), 32'd0);
        check_eq("midrst_ovr", 32'(bus.overrun), 32'd0);
        check_eq("midrst_l", bus.sample_l, 32'h0);
        check_eq("midrst_r", bus.sample_r, 32'h0);
        tick();
        HRESET = 1'b0;
        new_frames();
        wait_done(1200);
        check_eq("post_rst_l", bus.sample_l, fl[0]);
        check_eq("post_rst_r", bus.sample_r, fr[0]);
        run_random_until(2 * D * (FB * 3 + 5), 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
